// File: rtl/ifu_fetch.sv
// Instruction fetch: credit-limited in-order word fetch with a PC-tagged instruction buffer; grant->inst_valid_o 2 cycles at 1-cycle memory latency.
// Backpressure: issue stalls when outstanding + buffered reaches FIFO_DEPTH; redirect flushes the buffer and discards in-flight responses.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] ifq_wr_q, ifq_rd_q;
    logic [PW-1:0] buf_wr_q, buf_rd_q;
    logic [31:0]   ifq_pc_q   [FIFO_DEPTH];
    logic [31:0]   buf_pc_q   [FIFO_DEPTH];
    logic [31:0]   buf_inst_q [FIFO_DEPTH];
    logic [CW:0]   credit_used;
    logic          grant, drop, push, pop;

    assign credit_used  = {1'b0, out_q} + {1'b0, cnt_q};
    assign imem_req_o   = !redirect_i && (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_addr_o  = pc_q;
    assign grant        = imem_req_o && imem_gnt_i;
    assign drop         = imem_rvalid_i && (disc_q != '0);
    // A response landing in a redirect cycle belongs to the old stream, so it is never buffered.
    assign push         = imem_rvalid_i && (disc_q == '0) && !redirect_i;
    assign inst_valid_o = (cnt_q != '0);
    assign pop          = inst_valid_o && inst_ready_i && !redirect_i;
    assign inst_o       = inst_valid_o ? buf_inst_q[buf_rd_q] : 32'h0;
    assign inst_pc_o    = inst_valid_o ? buf_pc_q[buf_rd_q]   : 32'h0;

    always_comb begin
        pc_d   = pc_q;
        disc_d = disc_q;
        out_d  = out_q + CW'(grant) - CW'(imem_rvalid_i);
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        if (grant) begin
            pc_d = pc_q + 32'd4;
        end
        if (drop) begin
            disc_d = disc_q - CW'(1);
        end
        // No grant can happen in a redirect cycle, so out_d already excludes this cycle's response.
        if (redirect_i) begin
            pc_d   = redirect_pc_i & 32'hFFFF_FFFC;
            disc_d = out_d;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            cnt_q    <= '0;
            ifq_wr_q <= '0;
            ifq_rd_q <= '0;
            buf_wr_q <= '0;
            buf_rd_q <= '0;
        end else begin
            pc_q   <= pc_d;
            out_q  <= out_d;
            disc_q <= disc_d;
            cnt_q  <= cnt_d;
            if (grant) begin
                ifq_wr_q <= ifq_wr_q + PW'(1);
            end
            if (imem_rvalid_i) begin
                ifq_rd_q <= ifq_rd_q + PW'(1);
            end
            if (redirect_i) begin
                buf_wr_q <= '0;
                buf_rd_q <= '0;
            end else begin
                if (push) begin
                    buf_wr_q <= buf_wr_q + PW'(1);
                end
                if (pop) begin
                    buf_rd_q <= buf_rd_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) begin
            ifq_pc_q[ifq_wr_q] <= pc_q;
        end
        if (push) begin
            buf_pc_q[buf_wr_q]   <= ifq_pc_q[ifq_rd_q];
            buf_inst_q[buf_wr_q] <= imem_rdata_i;
        end
    end

    a_no_buf_overflow: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (disc_q == '0) && (cnt_q == CW'(FIFO_DEPTH))));
    a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
        !(imem_rvalid_i && (out_q == '0)));
endmodule
